// File: rtl/gcd_stein_coprocessor.sv
// FSL GCD coprocessor: reads operands A and B, reduces them with Stein's binary GCD at one step per cycle,
// and writes the GCD (plus an optional step count) back, stalling while the master FIFO is full.
module gcd_stein_coprocessor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  input  logic        FSL_S_Clk,
  output logic        FSL_S_Read,
  input  logic [0:31] FSL_S_Data,
  input  logic        FSL_S_Control,
  input  logic        FSL_S_Exists,
  input  logic        FSL_M_Clk,
  output logic        FSL_M_Write,
  output logic [0:31] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full
);

  localparam int K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {RD_A, RD_B, CALC, WR_RES, WR_CNT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               mode_q, mode_d;

  logic [31:0]        s_word_s;
  logic [31:0]        m_word_s;
  logic [WIDTH-1:0]   op_in_s;
  logic [WIDTH-1:0]   a_nxt_s, b_nxt_s;
  logic [K_W-1:0]     k_nxt_s;
  logic               unused_s;

  // The [0:31] FSL numbering keeps bit 31 as LSB, so a plain copy yields a conventional word.
  assign s_word_s   = FSL_S_Data;
  assign op_in_s    = s_word_s[WIDTH-1:0];
  assign FSL_M_Data = m_word_s;
  assign unused_s   = ^{FSL_S_Clk, FSL_M_Clk, s_word_s};

  // One Stein reduction step on the current operands (valid only when both are non-zero).
  always_comb begin
    a_nxt_s = a_q;
    b_nxt_s = b_q;
    k_nxt_s = k_q;
    if (!a_q[0] && !b_q[0]) begin
      a_nxt_s = a_q >> 1;
      b_nxt_s = b_q >> 1;
      k_nxt_s = k_q + K_W'(1);
    end else if (!a_q[0]) begin
      a_nxt_s = a_q >> 1;
    end else if (!b_q[0]) begin
      b_nxt_s = b_q >> 1;
    end else if (a_q >= b_q) begin
      a_nxt_s = (a_q - b_q) >> 1;
    end else begin
      b_nxt_s = (b_q - a_q) >> 1;
    end
  end

  // Next-state and FSL handshake outputs.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    k_d           = k_q;
    res_d         = res_q;
    steps_d       = steps_q;
    mode_d        = mode_q;
    FSL_S_Read    = 1'b0;
    FSL_M_Write   = 1'b0;
    FSL_M_Control = 1'b0;
    m_word_s      = 32'd0;
    case (state_q)
      RD_A: begin
        FSL_S_Read = FSL_S_Exists;
        if (FSL_S_Exists) begin
          a_d     = op_in_s;
          mode_d  = FSL_S_Control;
          state_d = RD_B;
        end else begin
          state_d = RD_A;
        end
      end
      RD_B: begin
        FSL_S_Read = FSL_S_Exists;
        if (FSL_S_Exists) begin
          b_d     = op_in_s;
          k_d     = '0;
          steps_d = '0;
          // A zero operand finishes immediately, so the write follows in the very next cycle.
          if (a_q == '0) begin
            res_d   = op_in_s;
            state_d = WR_RES;
          end else if (op_in_s == '0) begin
            res_d   = a_q;
            state_d = WR_RES;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = RD_B;
        end
      end
      CALC: begin
        if (a_q == '0) begin
          res_d   = b_q << k_q;
          state_d = WR_RES;
        end else if (b_q == '0) begin
          res_d   = a_q << k_q;
          state_d = WR_RES;
        end else begin
          a_d = a_nxt_s;
          b_d = b_nxt_s;
          k_d = k_nxt_s;
          if (steps_q != {CNT_W{1'b1}}) begin
            steps_d = steps_q + CNT_W'(1);
          end else begin
            steps_d = steps_q;
          end
          // Detect termination on the step that produces the zero to save a cycle.
          if (a_nxt_s == '0) begin
            res_d   = b_nxt_s << k_nxt_s;
            state_d = WR_RES;
          end else if (b_nxt_s == '0) begin
            res_d   = a_nxt_s << k_nxt_s;
            state_d = WR_RES;
          end else begin
            state_d = CALC;
          end
        end
      end
      WR_RES: begin
        m_word_s    = 32'(res_q);
        FSL_M_Write = !FSL_M_Full;
        if (!FSL_M_Full) begin
          state_d = mode_q ? WR_CNT : RD_A;
        end else begin
          state_d = WR_RES;
        end
      end
      WR_CNT: begin
        m_word_s      = 32'(steps_q);
        FSL_M_Control = 1'b1;
        FSL_M_Write   = !FSL_M_Full;
        if (!FSL_M_Full) begin
          state_d = RD_A;
        end else begin
          state_d = WR_CNT;
        end
      end
      default: begin
        state_d = RD_A;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge FSL_Clk) begin
    if (FSL_Rst) begin
      state_q <= RD_A;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      steps_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      res_q   <= res_d;
      steps_q <= steps_d;
      mode_q  <= mode_d;
    end
  end

endmodule
